pipe_stage_buf: RTL and testbench

- Parametrised pipeline stage buffer that generalises the single-entry valid/allowin stage register used between IF/ID/EX/MEM/WB.
- Holds up to DEPTH in-order payloads, plus a ready_go gate from the owning stage's logic, a synchronous flush and a saturating stall counter.
- Sits between two pipeline stages. With DEPTH=1 it behaves exactly like the existing stage registers; with DEPTH>1 it decouples stages, e.g. behind a multi-cycle data SRAM.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_buf_ram.sv | 40 ++++
 rtl/pipe_stage_buf.sv | 135 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the in-order pipeline stage buffers.
//
// Contents:
//   - payload bus widths between the pipeline stages (pc plus stage bus)
//   - clog2_cnt(depth): width of an occupancy counter that can hold 0..depth
//   - ptr_w(depth):     width of a pointer indexing 0..depth-1 (minimum 1 bit)
package pipe_pkg;

    localparam int PC_W    = 32;
    localparam int FS2DS_W = 64;
    localparam int DS2ES_W = 150;
    localparam int ES2MS_W = 71;
    localparam int MS2WS_W = 70;

    // Occupancy ranges over 0..depth, so it needs one more code than a pointer.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-entry buffer still needs a 1-bit pointer so the vectors stay legal.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_buf_ram.sv
// Payload storage for pipe_stage_buf.
//
// DEPTH x DATA_W register array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset: occupancy is
// tracked by the owner, so stale entries are never observed as valid.
//
// Ports:
//   clk    in            clock
//   we     in            write enable
//   waddr  in  ADDR_W    write index (0..DEPTH-1)
//   wdata  in  DATA_W    write data
//   raddr  in  ADDR_W    read index (0..DEPTH-1)
//   rdata  out DATA_W    entry at raddr, combinational
module pipe_buf_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // One enable per entry so non-power-of-2 depths never decode a phantom slot.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we && (waddr == ADDR_W'(gi))) begin
                mem_q[gi] <= wdata;
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// In-order pipeline stage buffer.
//
// Generalises the single-entry valid/allowin stage register: holds up to
// DEPTH payloads in FIFO order, gates the head with the owning stage's
// ready_go, supports a flush that discards everything, and counts cycles in
// which the head is offered but downstream refuses it (saturating).
// With DEPTH=1 it is equivalent to the classic stage register.
//
// Ports:
//   clk          in           clock
//   resetn       in           asynchronous active-low reset
//   flush        in           drop all entries at the next edge
//   in_valid     in           upstream payload valid
//   in_data      in  DATA_W   upstream payload
//   allowin      out          buffer accepts a payload this cycle
//   ready_go     in           owning stage has finished the head entry
//   out_valid    out          head payload offered downstream
//   out_allowin  in           downstream allowin
//   out_data     out DATA_W   head payload (don't-care when empty)
//   head_valid   out          buffer non-empty
//   count        out          occupancy, 0..DEPTH
//   stall_cnt    out CNT_W    cycles with out_valid & ~out_allowin, saturating
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          allowin,
    input  logic                          ready_go,
    output logic                          out_valid,
    input  logic                          out_allowin,
    output logic [DATA_W-1:0]             out_data,
    output logic                          head_valid,
    output logic [clog2_cnt(DEPTH)-1:0]   count,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int OCC_W = clog2_cnt(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic push;
    logic pop;

    // Explicit wrap so non-power-of-2 depths cycle 0..DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake. allowin includes pop so a full buffer can take a new payload
    // in the same cycle the head leaves; that makes allowin combinational in
    // out_allowin, just like the single-entry stage register.
    assign head_valid = (count_q != '0);
    assign out_valid  = head_valid & ready_go & ~flush;
    assign pop        = out_valid & out_allowin;
    assign allowin    = ~flush & ((count_q < DEPTH_C) | pop);
    assign push       = in_valid & allowin;

    assign count     = count_q;
    assign stall_cnt = stall_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        stall_d = stall_q;

        if (flush) begin
            // push/pop are already forced low by the gating above.
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Flush does not clear the statistic; it only stops counting because
        // out_valid is low during the flush cycle.
        if (out_valid && !out_allowin && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    pipe_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q),
        .wdata (in_data),
        .raddr (rptr_q),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- u1: DEPTH=1 ----------------
    logic        f1 = 0, iv1 = 0, rg1 = 0, oa1 = 0;
    logic [15:0] d1 = 0;
    logic        ai1, ov1, hv1;
    logic [15:0] od1;
    logic [0:0]  c1;
    logic [7:0]  s1;

    pipe_stage_buf #(.DATA_W(16), .DEPTH(1), .CNT_W(8)) u1 (
        .clk(clk), .resetn(resetn), .flush(f1), .in_valid(iv1), .in_data(d1),
        .allowin(ai1), .ready_go(rg1), .out_valid(ov1), .out_allowin(oa1),
        .out_data(od1), .head_valid(hv1), .count(c1), .stall_cnt(s1));

    // ---------------- u2: DEPTH=2, default widths ----------------
    logic        f2 = 0, iv2 = 0, rg2 = 0, oa2 = 0;
    logic [63:0] d2 = 0;
    logic        ai2, ov2, hv2;
    logic [63:0] od2;
    logic [1:0]  c2;
    logic [31:0] s2;

    pipe_stage_buf #(.DATA_W(64), .DEPTH(2), .CNT_W(32)) u2 (
        .clk(clk), .resetn(resetn), .flush(f2), .in_valid(iv2), .in_data(d2),
        .allowin(ai2), .ready_go(rg2), .out_valid(ov2), .out_allowin(oa2),
        .out_data(od2), .head_valid(hv2), .count(c2), .stall_cnt(s2));

    // ---------------- u3: DEPTH=3, CNT_W=4 ----------------
    logic        f3 = 0, iv3 = 0, rg3 = 0, oa3 = 0;
    logic [15:0] d3 = 0;
    logic        ai3, ov3, hv3;
    logic [15:0] od3;
    logic [1:0]  c3;
    logic [3:0]  s3;

    pipe_stage_buf #(.DATA_W(16), .DEPTH(3), .CNT_W(4)) u3 (
        .clk(clk), .resetn(resetn), .flush(f3), .in_valid(iv3), .in_data(d3),
        .allowin(ai3), .ready_go(rg3), .out_valid(ov3), .out_allowin(oa3),
        .out_data(od3), .head_valid(hv3), .count(c3), .stall_cnt(s3));

    // Vector: inputs applied for one cycle, expected outputs sampled before the edge.
    typedef struct {
        logic        fl, iv;
        logic [15:0] id;
        logic        rg, oa;
        logic        e_ai, e_ov, e_hv;
        logic [1:0]  e_cnt;
        logic [15:0] e_data;
        logic [3:0]  e_stall;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic fl, iv, input logic [15:0] id, input logic rg, oa,
                       input logic e_ai, e_ov, e_hv, input logic [1:0] e_cnt,
                       input logic [15:0] e_data, input logic [3:0] e_stall);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.rg = rg; v.oa = oa;
        v.e_ai = e_ai; v.e_ov = e_ov; v.e_hv = e_hv; v.e_cnt = e_cnt;
        v.e_data = e_data; v.e_stall = e_stall;
        tbl.push_back(v);
    endtask

    initial begin
        // Fill then block: D is offered while full and held upstream.
        add(0,1,16'hA,1,0, 1,0,0,2'd0,16'h0,4'd0);
        add(0,1,16'hB,1,0, 1,1,1,2'd1,16'hA,4'd0);
        add(0,1,16'hC,1,0, 1,1,1,2'd2,16'hA,4'd1);
        add(0,1,16'hD,1,0, 0,1,1,2'd3,16'hA,4'd2);
        add(0,1,16'hD,1,0, 0,1,1,2'd3,16'hA,4'd3);
        // Release: pop A and accept D in the same cycle, then drain.
        add(0,1,16'hD,1,1, 1,1,1,2'd3,16'hA,4'd4);
        add(0,0,16'h0,1,1, 1,1,1,2'd3,16'hB,4'd4);
        add(0,0,16'h0,1,1, 1,1,1,2'd2,16'hC,4'd4);
        add(0,0,16'h0,1,1, 1,1,1,2'd1,16'hD,4'd4);
        add(0,0,16'h0,1,1, 1,0,0,2'd0,16'h0,4'd4);
        // Refill to full, then five simultaneous push+pop (pointers wrap).
        add(0,1,16'h1,1,0, 1,0,0,2'd0,16'h0,4'd4);
        add(0,1,16'h2,1,0, 1,1,1,2'd1,16'h1,4'd4);
        add(0,1,16'h3,1,0, 1,1,1,2'd2,16'h1,4'd5);
        add(0,1,16'h4,1,1, 1,1,1,2'd3,16'h1,4'd6);
        add(0,1,16'h5,1,1, 1,1,1,2'd3,16'h2,4'd6);
        add(0,1,16'h6,1,1, 1,1,1,2'd3,16'h3,4'd6);
        add(0,1,16'h7,1,1, 1,1,1,2'd3,16'h4,4'd6);
        add(0,1,16'h8,1,1, 1,1,1,2'd3,16'h5,4'd6);
        add(0,0,16'h0,1,1, 1,1,1,2'd3,16'h6,4'd6);
        add(0,0,16'h0,1,1, 1,1,1,2'd2,16'h7,4'd6);
        add(0,0,16'h0,1,1, 1,1,1,2'd1,16'h8,4'd6);
        add(0,0,16'h0,1,1, 1,0,0,2'd0,16'h0,4'd6);
        // ready_go low gates out_valid and the stall counter.
        add(0,1,16'h9,1,1, 1,0,0,2'd0,16'h0,4'd6);
        add(0,0,16'h0,0,0, 1,0,1,2'd1,16'h9,4'd6);
        add(0,0,16'h0,1,1, 1,1,1,2'd1,16'h9,4'd6);
        add(0,0,16'h0,1,1, 1,0,0,2'd0,16'h0,4'd6);
    end

    initial begin
        // ---- reset state ----
        #2;
        chk("rst_count3", 64'(c3), 64'd0);
        chk("rst_stall3", 64'(s3), 64'd0);
        chk("rst_hv1", 64'(hv1), 64'd0);
        tick(); tick();
        resetn = 1'b1;
        #1;
        chk("rst_ai1", 64'(ai1), 64'd1);
        chk("rst_ai2", 64'(ai2), 64'd1);
        chk("rst_ai3", 64'(ai3), 64'd1);
        chk("rst_ov2", 64'(ov2), 64'd0);
        tick();

        // ---- DEPTH=1 streaming ----
        rg1 = 1; oa1 = 1;
        for (int i = 0; i < 5; i++) begin
            iv1 = (i < 3);
            d1  = 16'(i + 1);
            @(negedge clk);
            chk($sformatf("d1_ai[%0d]", i), 64'(ai1), 64'd1);
            chk($sformatf("d1_cnt[%0d]", i), 64'(c1), (i == 0 || i == 4) ? 64'd0 : 64'd1);
            if (i >= 1 && i <= 3) chk($sformatf("d1_data[%0d]", i), 64'(od1), 64'(i));
            tick();
        end
        // DEPTH=1 full with downstream blocked: no room.
        iv1 = 1; d1 = 16'h77; oa1 = 0;
        tick();
        iv1 = 0;
        @(negedge clk);
        chk("d1_full_ai", 64'(ai1), 64'd0);
        chk("d1_full_data", 64'(od1), 64'h77);
        rg1 = 0;
        #1;
        chk("d1_rg0_ov", 64'(ov1), 64'd0);
        tick();
        rg1 = 1; oa1 = 1;
        tick();
        chk("d1_drain", 64'(c1), 64'd0);

        // ---- table vectors on DEPTH=3 ----
        foreach (tbl[i]) begin
            f3 = tbl[i].fl; iv3 = tbl[i].iv; d3 = tbl[i].id;
            rg3 = tbl[i].rg; oa3 = tbl[i].oa;
            @(negedge clk);
            chk($sformatf("v%0d_allowin", i), 64'(ai3), 64'(tbl[i].e_ai));
            chk($sformatf("v%0d_out_valid", i), 64'(ov3), 64'(tbl[i].e_ov));
            chk($sformatf("v%0d_head_valid", i), 64'(hv3), 64'(tbl[i].e_hv));
            chk($sformatf("v%0d_count", i), 64'(c3), 64'(tbl[i].e_cnt));
            chk($sformatf("v%0d_stall", i), 64'(s3), 64'(tbl[i].e_stall));
            if (tbl[i].e_hv) chk($sformatf("v%0d_data", i), 64'(od3), 64'(tbl[i].e_data));
            tick();
        end
        iv3 = 0;

        // ---- DEPTH=2 flush ----
        rg2 = 1; oa2 = 0; iv2 = 1; d2 = 64'h11;
        tick();
        d2 = 64'h22;
        tick();
        chk("fl_pre_count", 64'(c2), 64'd2);
        f2 = 1; d2 = 64'h33; oa2 = 1;
        #1;
        chk("fl_allowin", 64'(ai2), 64'd0);
        chk("fl_out_valid", 64'(ov2), 64'd0);
        tick();
        f2 = 0; iv2 = 0;
        #1;
        chk("fl_count", 64'(c2), 64'd0);
        chk("fl_head_valid", 64'(hv2), 64'd0);
        chk("fl_stall_kept", 64'(s2), 64'd1);
        iv2 = 1; d2 = 64'h44;
        tick();
        iv2 = 0; rg2 = 0; oa2 = 1;
        #1;
        chk("fl_push_count", 64'(c2), 64'd1);
        chk("fl_push_data", 64'(od2), 64'h44);

        // ---- ready_go low holds the head ----
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rg_ov[%0d]", i), 64'(ov2), 64'd0);
            chk($sformatf("rg_head[%0d]", i), 64'(od2), 64'h44);
            chk($sformatf("rg_ai[%0d]", i), 64'(ai2), 64'd1);
            tick();
        end
        chk("rg_stall", 64'(s2), 64'd1);
        rg2 = 1;
        #1;
        chk("rg_release_ov", 64'(ov2), 64'd1);
        tick();
        chk("rg_popped", 64'(c2), 64'd0);

        // ---- stall counter saturation on CNT_W=4, then async reset ----
        iv3 = 1; d3 = 16'h55; rg3 = 1; oa3 = 0;
        tick();
        iv3 = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", 64'(s3), 64'd15);
        chk("sat_ov", 64'(ov3), 64'd1);
        chk("sat_head", 64'(od3), 64'h55);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_count", 64'(c3), 64'd0);
        chk("arst_stall", 64'(s3), 64'd0);
        chk("arst_ov", 64'(ov3), 64'd0);
        chk("arst_stall2", 64'(s2), 64'd0);
        tick();
        resetn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
